// File: rtl/store_merge_unit.sv
// store_merge_unit: SB/SH/SW store path for word-organised data memory.
// Sub-word stores read the word, merge the selected lanes and write it back.
// Word stores skip the read. Misaligned or reserved-size requests complete
// with Error and never touch memory.
module store_merge_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           Data,
  input  logic [1:0]            Size,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [ADDR_WIDTH-3:0] MemAddr,
  output logic [31:0]           MemWData,
  input  logic [31:0]           MemRData,
  input  logic                  MemAck
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned HALF_WIDTH = 16;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t                  state;
  logic [1:0]              offset_q;
  logic [HALF_WIDTH-1:0]   data_q;
  logic                    half_q;
  logic [DATA_WIDTH-1:0]   merged_c;
  logic                    bad_req_c;
  logic                    ack_c;

  // Reserved size, odd halfword or non-word-aligned word is rejected up front.
  always_comb begin
    bad_req_c = (Size == SIZE_RSVD) ||
                ((Size == SIZE_HALF) && Addr[0]) ||
                ((Size == SIZE_WORD) && (Addr[1:0] != 2'b00));
  end

  // Ack only counts while a request is actually outstanding.
  always_comb begin
    ack_c = MemReq && MemAck;
  end

  // Little-endian lane merge of the latched store data into the read word.
  always_comb begin
    merged_c = MemRData;
    if (half_q) begin
      if (offset_q[1]) begin
        merged_c[31:16] = data_q;
      end else begin
        merged_c[15:0] = data_q;
      end
    end else begin
      merged_c[{offset_q, 3'b000} +: 8] = data_q[7:0];
    end
  end

  // Transaction FSM with registered handshake and status outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      offset_q <= 2'b00;
      data_q   <= '0;
      half_q   <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            MemAddr  <= Addr[ADDR_WIDTH-1:2];
            offset_q <= Addr[1:0];
            data_q   <= Data[HALF_WIDTH-1:0];
            half_q   <= Size[0];
            Busy     <= 1'b1;
            if (bad_req_c) begin
              state <= FIN;
              Done  <= 1'b1;
              Error <= 1'b1;
            end else if (Size == SIZE_WORD) begin
              state    <= WR;
              MemReq   <= 1'b1;
              MemWe    <= 1'b1;
              MemWData <= Data;
            end else begin
              state  <= RD;
              MemReq <= 1'b1;
              MemWe  <= 1'b0;
            end
          end
        end
        RD: begin
          if (ack_c) begin
            state    <= WR;
            MemWe    <= 1'b1;
            MemWData <= merged_c;
          end
        end
        WR: begin
          if (ack_c) begin
            state  <= FIN;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            Done   <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          Busy   <= 1'b0;
          MemReq <= 1'b0;
          MemWe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed vector table plus hand-written corner sequences.
module tb_store_merge_unit;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned MAX_CYC    = 50;

  logic                  Clk;
  logic                  Reset_n;
  logic                  Start;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [31:0]           Data;
  logic [1:0]            Size;
  logic                  Busy;
  logic                  Done;
  logic                  Error;
  logic                  MemReq;
  logic                  MemWe;
  logic [ADDR_WIDTH-3:0] MemAddr;
  logic [31:0]           MemWData;
  logic [31:0]           MemRData;
  logic                  MemAck;

  logic                  resp_ack;
  logic                  force_ack;
  logic [31:0]           cur_rdata;
  int                    ack_delay;
  int                    wait_cnt;
  int                    rd_count;
  int                    wr_count;
  int                    req_cycles;
  int                    req_drop;
  int                    addr_bad;
  logic [29:0]           last_raddr;
  logic [29:0]           last_waddr;
  logic [31:0]           last_wdata;
  logic [29:0]           exp_addr;

  int tests;
  int failed;

  assign MemAck   = resp_ack | force_ack;
  assign MemRData = cur_rdata;

  store_merge_unit #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Addr     (Addr),
    .Data     (Data),
    .Size     (Size),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error),
    .MemReq   (MemReq),
    .MemWe    (MemWe),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .MemRData (MemRData),
    .MemAck   (MemAck)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Memory responder: acks each request after ack_delay wait cycles, logs accesses.
  initial begin
    resp_ack = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge Clk);
      if (MemReq) begin
        req_cycles++;
        if (MemAddr !== exp_addr) addr_bad++;
        if (wait_cnt >= ack_delay) begin
          resp_ack = 1'b1;
          wait_cnt = 0;
          if (MemWe) begin
            wr_count++;
            last_waddr = MemAddr;
            last_wdata = MemWData;
          end else begin
            rd_count++;
            last_raddr = MemAddr;
          end
        end else begin
          resp_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        if (wait_cnt > 0) req_drop++;
        resp_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    rd_count   = 0;
    wr_count   = 0;
    req_cycles = 0;
    req_drop   = 0;
    addr_bad   = 0;
    last_raddr = '0;
    last_waddr = '0;
    last_wdata = '0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_wdata;
    logic [29:0] exp_waddr;
    int          exp_rd;
    int          exp_wr;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  // One table-driven transaction: issue, wait for Done, compare everything observed.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int busy_bad;
    int err_bad;
    string nm;
    nm = $sformatf("v%0d", idx);
    cur_rdata = v.rdata;
    ack_delay = v.delay;
    exp_addr  = v.addr[31:2];
    clear_log();
    busy_bad = 0;
    err_bad  = 0;
    @(negedge Clk);
    Addr  = v.addr;
    Data  = v.data;
    Size  = v.size;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < MAX_CYC) begin
      if (!Busy) busy_bad++;
      if (Error) err_bad++;
      @(negedge Clk);
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({nm, "_busy_at_done"}, 32'(Busy), 32'd1);
    check({nm, "_error"}, 32'(Error), 32'(v.exp_err));
    check({nm, "_busy_during"}, 32'(busy_bad), 32'd0);
    check({nm, "_error_early"}, 32'(err_bad), 32'd0);
    @(negedge Clk);
    check({nm, "_done_pulse"}, 32'({Done, Error, Busy}), 32'd0);
    check({nm, "_reads"}, 32'(rd_count), 32'(v.exp_rd));
    check({nm, "_writes"}, 32'(wr_count), 32'(v.exp_wr));
    check({nm, "_addr_stable"}, 32'(addr_bad), 32'd0);
    check({nm, "_req_held"}, 32'(req_drop), 32'd0);
    if (v.exp_err) begin
      check({nm, "_no_req"}, 32'(req_cycles), 32'd0);
    end else begin
      check({nm, "_waddr"}, 32'(last_waddr), 32'(v.exp_waddr));
      check({nm, "_wdata"}, last_wdata, v.exp_wdata);
      if (v.exp_rd != 0) check({nm, "_raddr"}, 32'(last_raddr), 32'(v.exp_waddr));
    end
  endtask

  initial begin
    int lat;
    int done_seen;
    tests     = 0;
    failed    = 0;
    force_ack = 1'b0;
    cur_rdata = 32'h0;
    ack_delay = 0;
    exp_addr  = '0;
    clear_log();
    Reset_n = 1'b0;
    Start   = 1'b0;
    Addr    = '0;
    Data    = '0;
    Size    = 2'b00;

    //            addr          data          sz     rdata         dly wdata         waddr        rd wr lat err
    vecs[0]  = '{32'h101, 32'hDEADBEAB, 2'b00, 32'h11223344, 0, 32'h1122AB44, 30'h40, 1, 1, 3, 1'b0};
    vecs[1]  = '{32'h102, 32'h1234BEEF, 2'b01, 32'h11223344, 3, 32'hBEEF3344, 30'h40, 1, 1, 9, 1'b0};
    vecs[2]  = '{32'h104, 32'hCAFEF00D, 2'b10, 32'h11223344, 0, 32'hCAFEF00D, 30'h41, 0, 1, 2, 1'b0};
    vecs[3]  = '{32'h100, 32'h000000EE, 2'b00, 32'hAABBCCDD, 0, 32'hAABBCCEE, 30'h40, 1, 1, 3, 1'b0};
    vecs[4]  = '{32'h103, 32'hFFFFFF77, 2'b00, 32'hAABBCCDD, 0, 32'h77BBCCDD, 30'h40, 1, 1, 3, 1'b0};
    vecs[5]  = '{32'h102, 32'h12345655, 2'b00, 32'h00000000, 0, 32'h00550000, 30'h40, 1, 1, 3, 1'b0};
    vecs[6]  = '{32'h100, 32'hFFFF0123, 2'b01, 32'h89ABCDEF, 0, 32'h89AB0123, 30'h40, 1, 1, 3, 1'b0};
    vecs[7]  = '{32'h200, 32'h01234567, 2'b10, 32'h0,        1, 32'h01234567, 30'h80, 0, 1, 3, 1'b0};
    vecs[8]  = '{32'h105, 32'h00000022, 2'b00, 32'h11111111, 2, 32'h11112211, 30'h41, 1, 1, 7, 1'b0};
    vecs[9]  = '{32'h103, 32'h00001234, 2'b01, 32'h0,        0, 32'h0,        30'h0,  0, 0, 1, 1'b1};
    vecs[10] = '{32'h106, 32'h12345678, 2'b10, 32'h0,        0, 32'h0,        30'h0,  0, 0, 1, 1'b1};
    vecs[11] = '{32'h100, 32'h12345678, 2'b11, 32'h0,        0, 32'h0,        30'h0,  0, 0, 1, 1'b1};
    vecs[12] = '{32'h101, 32'h0000ABCD, 2'b01, 32'h0,        0, 32'h0,        30'h0,  0, 0, 1, 1'b1};

    // Reset held with Start and MemAck asserted: everything stays at zero.
    Start     = 1'b1;
    force_ack = 1'b1;
    Addr      = 32'h101;
    Data      = 32'hDEADBEAB;
    repeat (3) @(negedge Clk);
    check("rst_outputs", {25'd0, Busy, Done, Error, MemReq, MemWe, 2'b00}, 32'd0);
    check("rst_memaddr", 32'(MemAddr), 32'd0);
    check("rst_memwdata", MemWData, 32'd0);
    check("rst_no_req", 32'(req_cycles), 32'd0);
    Reset_n = 1'b1;
    Start   = 1'b0;
    // Stray ack in IDLE must not start anything.
    repeat (2) @(negedge Clk);
    check("idle_stray_ack", {29'd0, Busy, MemReq, Done}, 32'd0);
    force_ack = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_vec(i, vecs[i]);
    end

    // Start pulsed while busy and again in the FIN cycle: only one write happens.
    clear_log();
    cur_rdata = 32'h55555555;
    ack_delay = 3;
    exp_addr  = 30'h41;
    @(negedge Clk);
    Addr  = 32'h104;
    Data  = 32'hCAFEF00D;
    Size  = 2'b10;
    Start = 1'b1;
    @(negedge Clk);
    Addr  = 32'h200;
    Data  = 32'h00000099;
    Size  = 2'b00;
    lat   = 1;
    @(negedge Clk);
    lat++;
    Start = 1'b0;
    while (!Done && lat < MAX_CYC) begin
      @(negedge Clk);
      lat++;
    end
    check("busy_start_latency", 32'(lat), 32'd5);
    Addr  = 32'h300;
    Data  = 32'h00000005;
    Size  = 2'b10;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("fin_start_busy", 32'({Busy, MemReq}), 32'd0);
    repeat (4) @(negedge Clk);
    check("busy_start_writes", 32'(wr_count), 32'd1);
    check("busy_start_reads", 32'(rd_count), 32'd0);
    check("busy_start_wdata", last_wdata, 32'hCAFEF00D);
    check("busy_start_waddr", 32'(last_waddr), 32'h41);
    check("fin_start_no_req", 32'(Busy), 32'd0);

    // Reset during RD wait: request dropped, no write ever issued.
    clear_log();
    cur_rdata = 32'h11223344;
    ack_delay = 6;
    exp_addr  = 30'h40;
    @(negedge Clk);
    Addr  = 32'h101;
    Data  = 32'h000000AB;
    Size  = 2'b00;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    check("rd_wait_req", 32'({MemReq, MemWe}), 32'b10);
    Reset_n = 1'b0;
    @(negedge Clk);
    check("rd_rst_req_drop", 32'({MemReq, MemWe, Busy}), 32'd0);
    Reset_n   = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge Clk);
      if (Done || MemReq) done_seen++;
    end
    check("rd_rst_no_write", 32'(wr_count), 32'd0);
    check("rd_rst_no_activity", 32'(done_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
